param_processor: RTL and testbench

Parametrised multicycle processor core: the next generation of the team's 16-bit teaching processor. It has a generic data width and memory address width, Z/N/C condition flags, conditional and linking branches, and a ready/valid memory port that tolerates wait states. It sits between the board top level and an external instruction/data memory. Debug outputs expose PC, IR and flags to the board displays.

---
 rtl/proc_pkg.sv | 59 +++++
 rtl/proc_alu.sv | 33 +++
 rtl/param_processor.sv | 161 ++++++++++++++++
 tb/tb_param_processor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the parametrised multicycle core: opcodes, branch conditions,
// FSM states, instruction field positions and the branch-condition evaluator.
package proc_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'd0,
    OP_MVT = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5,
    OP_AND = 3'd6,
    OP_BR  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    CC_AL = 3'd0,
    CC_EQ = 3'd1,
    CC_NE = 3'd2,
    CC_CC = 3'd3,
    CC_CS = 3'd4,
    CC_PL = 3'd5,
    CC_MI = 3'd6,
    CC_BL = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_MEM    = 2'd3
  } state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int IMM_BIT = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 9;
  localparam int IMM_MSB = 8;
  localparam int RY_MSB  = 2;

  function automatic logic cond_true(input cond_e cc, input logic n, input logic z,
                                     input logic c);
    logic res;
    case (cc)
      CC_AL:   res = 1'b1;
      CC_EQ:   res = z;
      CC_NE:   res = ~z;
      CC_CC:   res = ~c;
      CC_CS:   res = c;
      CC_PL:   res = ~n;
      CC_MI:   res = n;
      CC_BL:   res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub/and on DATA_W operands with N/Z/C outputs.
// Subtraction is a + ~b + 1, so C=1 means no borrow.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] wide_s;

  // One extra bit on the sum carries C out of the top of the word.
  always_comb begin
    case (op)
      OP_ADD:  wide_s = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide_s = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
      OP_AND:  wide_s = {1'b0, a & b};
      default: wide_s = {1'b0, b};
    endcase
    result = wide_s[DATA_W-1:0];
    c      = wide_s[DATA_W];
    n      = wide_s[DATA_W-1];
    z      = (wide_s[DATA_W-1:0] == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/param_processor.sv
// Multicycle core: R0-R6 plus PC (R7), IR, {N,Z,C} flags and an
// IDLE/FETCH/DECODE/MEM sequencer driving a ready/valid memory port.
module param_processor
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic              done,
  output logic [2:0]        flags,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] ir_out
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [0:6];
  logic [DATA_W-1:0] regs_d [0:6];
  logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d;
  logic [2:0]        flags_q, flags_d;

  op_e               op_s;
  logic              imm_s;
  logic [2:0]        rx_s, ry_s;
  logic [8:0]        imm9_s;
  logic [DATA_W-1:0] rx_val_s, ry_val_s, operand_s, br_off_s, alu_res_s, wr_val_s;
  logic              alu_n_s, alu_z_s, alu_c_s, wr_en_s;

  assign op_s      = op_e'(ir_q[OP_MSB:OP_LSB]);
  assign imm_s     = ir_q[IMM_BIT];
  assign rx_s      = ir_q[RX_MSB:RX_LSB];
  assign ry_s      = ir_q[RY_MSB:0];
  assign imm9_s    = ir_q[IMM_MSB:0];
  assign rx_val_s  = (rx_s == 3'd7) ? pc_q : regs_q[rx_s];
  assign ry_val_s  = (ry_s == 3'd7) ? pc_q : regs_q[ry_s];
  assign operand_s = imm_s ? {{(DATA_W-9){1'b0}}, imm9_s} : ry_val_s;
  assign br_off_s  = {{(DATA_W-9){imm9_s[8]}}, imm9_s};

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (rx_val_s),
    .b      (operand_s),
    .op     (op_s),
    .result (alu_res_s),
    .n      (alu_n_s),
    .z      (alu_z_s),
    .c      (alu_c_s)
  );

  // Sequencer: next state, register/flag updates and memory strobes.
  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    done     = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q[ADDR_W-1:0];
    wr_en_s  = 1'b0;
    wr_val_s = operand_s;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ONE;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        done = 1'b1;
        case (op_s)
          OP_MV:  wr_en_s = 1'b1;
          OP_MVT: begin
            wr_en_s  = 1'b1;
            wr_val_s = {imm9_s[7:0], {(DATA_W-8){1'b0}}};
          end
          OP_ADD, OP_SUB, OP_AND: begin
            wr_en_s  = 1'b1;
            wr_val_s = alu_res_s;
            flags_d  = {alu_n_s, alu_z_s, (op_s == OP_AND) ? flags_q[0] : alu_c_s};
          end
          OP_LD, OP_ST: done = 1'b0;
          OP_BR: begin
            if (cond_true(cond_e'(rx_s), flags_q[2], flags_q[1], flags_q[0])) begin
              pc_d = pc_q + br_off_s;
            end else begin
              pc_d = pc_q;
            end
            if (cond_e'(rx_s) == CC_BL) regs_d[6] = pc_q;
            else                        regs_d[6] = regs_q[6];
          end
          default: done = 1'b1;
        endcase
        if (done)                                     state_d = run ? S_FETCH : S_IDLE;
        else                                          state_d = S_MEM;
      end
      S_MEM: begin
        mem_addr = ry_val_s[ADDR_W-1:0];
        mem_re   = (op_s == OP_LD);
        mem_we   = (op_s == OP_ST);
        if (mem_ready) begin
          done     = 1'b1;
          wr_en_s  = (op_s == OP_LD);
          wr_val_s = mem_rdata;
          state_d  = run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_MEM;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A write to R7 is a jump and overrides the fetch increment.
    if (wr_en_s) begin
      if (rx_s == 3'd7) pc_d = wr_val_s;
      else              regs_d[rx_s] = wr_val_s;
    end else begin
      pc_d = pc_d;
    end
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= {DATA_W{1'b0}};
      ir_q    <= {DATA_W{1'b0}};
      flags_q <= 3'b000;
      for (int i = 0; i < 7; i++) regs_q[i] <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      regs_q  <= regs_d;
    end
  end

  assign mem_wdata = rx_val_s;
  assign flags     = flags_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_param_processor.sv
// Scoreboard bench for param_processor: a memory model with per-region wait
// states, an instruction-completion monitor and a store monitor.
module tb_param_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re, mem_we, done;
  logic [2:0]  flags;
  logic [15:0] pc_out, ir_out;

  param_processor #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .done(done), .flags(flags), .pc_out(pc_out), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    int          cyc;
    logic [15:0] pc;
    logic [2:0]  fl;
  } exp_t;
  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } st_t;

  exp_t        exp_q[$];
  st_t         st_q[$];
  logic [15:0] mem [0:255];
  int          n_chk = 0;
  int          n_err = 0;
  int          data_wait = 0;
  int          last_rd_hold = 0;
  bit          mon_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int imm, input int rx, input int v);
    return {op[2:0], imm[0], rx[2:0], v[8:0]};
  endfunction

  task automatic ex(input logic [15:0] ir, input int cyc, input logic [15:0] pc,
                    input logic [2:0] fl);
    exp_t e;
    e.ir = ir; e.cyc = cyc; e.pc = pc; e.fl = fl;
    exp_q.push_back(e);
  endtask

  task automatic exst(input logic [7:0] a, input logic [15:0] d);
    st_t s;
    s.a = a; s.d = d;
    st_q.push_back(s);
  endtask

  task automatic clear_all();
    reset = 1'b1;
    run   = 1'b0;
    exp_q.delete();
    st_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic run_prog();
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    for (int i = 0; i < 400 && (exp_q.size() != 0 || st_q.size() != 0 || mon_busy); i++)
      @(negedge clk);
    chk("pending", exp_q.size() + st_q.size(), 0);
    run = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
  endtask

  // Memory model: addresses >= 0x20 insert data_wait wait states.
  initial begin
    int wcnt, hold, need;
    wcnt = 0; hold = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        wcnt = 0; hold = 0; mem_ready = 1'b0;
      end else if (mem_re || mem_we) begin
        hold++;
        need = (mem_addr >= 8'h20) ? data_wait : 0;
        if (wcnt < need) begin
          wcnt++;
          mem_ready = 1'b0;
        end else begin
          mem_ready = 1'b1;
          if (mem_re) begin
            mem_rdata = mem[mem_addr];
            if (mem_addr >= 8'h20) last_rd_hold = hold;
          end else begin
            mem[mem_addr] = mem_wdata;
          end
          wcnt = 0; hold = 0;
        end
      end else begin
        mem_ready = 1'b0; wcnt = 0; hold = 0;
      end
    end
  end

  // Completion monitor: IR and cycle count on done, PC/flags after the edge.
  initial begin
    bit   started;
    int   cnt;
    exp_t e;
    started = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        started = 1'b0; cnt = 0;
      end else begin
        if (!started && mem_re) started = 1'b1;
        if (started) cnt++;
        if (done) begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            mon_busy = 1'b1;
            chk("ir", ir_out, e.ir);
            chk("cycles", cnt, e.cyc);
            cnt = 0;
            @(posedge clk);
            #1;
            chk("pc", pc_out, e.pc);
            chk("flags", flags, e.fl);
            mon_busy = 1'b0;
          end else begin
            cnt = 0;
          end
        end
      end
    end
  end

  // Store monitor: each completed store is matched against the store queue.
  initial begin
    st_t s;
    forever begin
      @(negedge clk);
      if (!reset && mem_we && mem_ready) begin
        if (st_q.size() != 0) begin
          s = st_q.pop_front();
          chk("st_addr", mem_addr, s.a);
          chk("st_data", mem_wdata, s.d);
        end else begin
          chk("st_extra", st_q.size(), 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b1;
    #2;
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_flags", flags, 0);

    // mv r0,#5 ; add r0,#3 ; store r0 to 0x30
    clear_all(); data_wait = 0;
    mem[0] = enc(0, 1, 0, 5);     ex(mem[0], 2, 16'h0001, 3'b000);
    mem[1] = enc(2, 1, 0, 3);     ex(mem[1], 2, 16'h0002, 3'b000);
    mem[2] = enc(0, 1, 1, 'h30);  ex(mem[2], 2, 16'h0003, 3'b000);
    mem[3] = enc(5, 0, 0, 1);     ex(mem[3], 3, 16'h0004, 3'b000); exst(8'h30, 16'h0008);
    mem[4] = enc(7, 1, 0, 'h1FF);
    run_prog();

    // r1 = 0xFFFF ; +1 wraps to 0 with carry ; -1 borrows back to 0xFFFF
    clear_all(); data_wait = 0;
    mem[0] = enc(1, 1, 1, 'hFF);  ex(mem[0], 2, 16'h0001, 3'b000);
    mem[1] = enc(2, 1, 1, 'hFF);  ex(mem[1], 2, 16'h0002, 3'b100);
    mem[2] = enc(2, 1, 1, 1);     ex(mem[2], 2, 16'h0003, 3'b011);
    mem[3] = enc(3, 1, 1, 1);     ex(mem[3], 2, 16'h0004, 3'b100);
    mem[4] = enc(0, 1, 2, 'h30);  ex(mem[4], 2, 16'h0005, 3'b100);
    mem[5] = enc(5, 0, 1, 2);     ex(mem[5], 3, 16'h0006, 3'b100); exst(8'h30, 16'hFFFF);
    mem[6] = enc(7, 1, 0, 'h1FF);
    run_prog();

    // beq -3 taken: back to address 0, flags untouched by the re-executed mv
    clear_all(); data_wait = 0;
    mem[0] = enc(0, 1, 2, 7);     ex(mem[0], 2, 16'h0001, 3'b000);
    mem[1] = enc(3, 1, 2, 7);     ex(mem[1], 2, 16'h0002, 3'b011);
    mem[2] = enc(7, 0, 1, 'h1FD); ex(mem[2], 2, 16'h0000, 3'b011);
    ex(mem[0], 2, 16'h0001, 3'b011);
    run_prog();

    // bne -3 not taken: falls through
    clear_all(); data_wait = 0;
    mem[0] = enc(0, 1, 2, 7);     ex(mem[0], 2, 16'h0001, 3'b000);
    mem[1] = enc(3, 1, 2, 7);     ex(mem[1], 2, 16'h0002, 3'b011);
    mem[2] = enc(7, 0, 2, 'h1FD); ex(mem[2], 2, 16'h0003, 3'b011);
    mem[3] = enc(0, 1, 3, 1);     ex(mem[3], 2, 16'h0004, 3'b011);
    mem[4] = enc(7, 1, 0, 'h1FF);
    run_prog();

    // jump via mv r7 to 0x10, bl +4 links R6=0x11 and lands at 0x15
    clear_all(); data_wait = 0;
    mem[0]     = enc(0, 1, 5, 'h30); ex(mem[0], 2, 16'h0001, 3'b000);
    mem[1]     = enc(0, 1, 7, 'h10); ex(mem[1], 2, 16'h0010, 3'b000);
    mem['h10]  = enc(7, 0, 7, 4);    ex(mem['h10], 2, 16'h0015, 3'b000);
    mem['h15]  = enc(5, 0, 6, 5);    ex(mem['h15], 3, 16'h0016, 3'b000); exst(8'h30, 16'h0011);
    mem['h16]  = enc(7, 1, 0, 'h1FF);
    run_prog();

    // ld r3,[r4] from 0x20 with 3 wait states, then store r3 (also waited)
    clear_all(); data_wait = 3; last_rd_hold = 0;
    mem['h20] = 16'hBEEF;
    mem[0] = enc(0, 1, 4, 'h20);  ex(mem[0], 2, 16'h0001, 3'b000);
    mem[1] = enc(4, 0, 3, 4);     ex(mem[1], 6, 16'h0002, 3'b000);
    mem[2] = enc(0, 1, 5, 'h30);  ex(mem[2], 2, 16'h0003, 3'b000);
    mem[3] = enc(5, 0, 3, 5);     ex(mem[3], 6, 16'h0004, 3'b000); exst(8'h30, 16'hBEEF);
    mem[4] = enc(7, 1, 0, 'h1FF);
    run_prog();
    chk("ld_re_hold", last_rd_hold, 4);

    // reset in the second wait cycle of a store abandons it; restart fetches from 0
    clear_all(); data_wait = 3;
    mem[0] = enc(0, 1, 1, 'h30);  ex(mem[0], 2, 16'h0001, 3'b000);
    mem[1] = enc(5, 0, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    for (int i = 0; i < 50 && !mem_we; i++) @(negedge clk);
    chk("st_strobe", mem_we, 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("ar_we", mem_we, 0);
    chk("ar_re", mem_re, 0);
    chk("ar_done", done, 0);
    chk("ar_pc", pc_out, 0);
    chk("ar_ir", ir_out, 0);
    chk("ar_flags", flags, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50 && !mem_re; i++) @(negedge clk);
    chk("refetch_re", mem_re, 1);
    chk("refetch_addr", mem_addr, 0);
    run = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
